// File: rtl/puf_pkg.sv
// Shared types for the ring-oscillator PUF pair evaluator: FSM states,
// settle length and the registered response flag pair.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        RESP
    } state_e;

    localparam int SETTLE_CYCLES = 4;

    typedef struct packed {
        logic bit_v;
        logic tie;
    } rsp_flags_t;

endpackage

// File: rtl/puf_ro_edge_sync.sv
// Synchroniser for one asynchronous RO toggle line; emits a one-cycle pulse
// on every change of the synchronised level (both polarities).
module puf_ro_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/puf_ro_pair_eval.sv
// RO PUF pair evaluator: counts edges of two selected oscillators over a gate
// window for a number of rounds and returns a majority-voted response bit.
module puf_ro_pair_eval
    import puf_pkg::*;
#(
    parameter int N_RO        = 16,
    parameter int SEL_W       = $clog2(N_RO),
    parameter int CNT_W       = 20,
    parameter int WIN_W       = 16,
    parameter int VOTE_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_RO-1:0]   ro_tgl,
    input  logic              chal_valid,
    output logic              chal_ready,
    input  logic [SEL_W-1:0]  chal_sel_a,
    input  logic [SEL_W-1:0]  chal_sel_b,
    input  logic [WIN_W-1:0]  chal_win,
    input  logic [VOTE_W-1:0] chal_votes,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_bit,
    output logic              rsp_tie,
    output logic [VOTE_W-1:0] rsp_wins,
    output logic [CNT_W-1:0]  rsp_cnt_a,
    output logic [CNT_W-1:0]  rsp_cnt_b,
    output logic              busy
);

    localparam logic [SEL_W:0]   N_RO_L      = (SEL_W+1)'(N_RO);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);

    logic [N_RO-1:0]   edge_vec;
    state_e            state;
    logic [SEL_W-1:0]  sel_a_q, sel_b_q;
    logic [WIN_W-1:0]  win_q, tmr;
    logic [VOTE_W-1:0] votes_q, wins, round;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    rsp_flags_t        flags_q;
    logic              edge_a, edge_b;
    logic [VOTE_W-1:0] wins_nx, round_nx;

    for (genvar i = 0; i < N_RO; i++) begin : g_sync
        puf_ro_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk       (clk),
            .rst       (rst),
            .ro_in     (ro_tgl[i]),
            .edge_pulse(edge_vec[i])
        );
    end

    // Indices past the last oscillator fall back to line 0 instead of wrapping.
    function automatic logic pick(input logic [N_RO-1:0] v, input logic [SEL_W-1:0] s);
        if ({1'b0, s} < N_RO_L) return v[s];
        return v[0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        edge_a   = pick(edge_vec, sel_a_q);
        edge_b   = pick(edge_vec, sel_b_q);
        wins_nx  = wins + VOTE_W'(cnt_a > cnt_b);
        round_nx = round + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            win_q     <= '0;
            votes_q   <= '0;
            tmr       <= '0;
            wins      <= '0;
            round     <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            flags_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_wins  <= '0;
            rsp_cnt_a <= '0;
            rsp_cnt_b <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (chal_valid) begin
                        sel_a_q <= chal_sel_a;
                        sel_b_q <= chal_sel_b;
                        win_q   <= (chal_win == '0) ? WIN_W'(1) : chal_win;
                        votes_q <= (chal_votes == '0) ? VOTE_W'(1) : chal_votes;
                        wins    <= '0;
                        round   <= '0;
                        tmr     <= '0;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                    if (tmr == SETTLE_LAST) begin
                        tmr   <= '0;
                        state <= COUNT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                COUNT: begin
                    if (edge_a) cnt_a <= sat_inc(cnt_a);
                    if (edge_b) cnt_b <= sat_inc(cnt_b);
                    if (tmr == win_q - 1'b1) begin
                        tmr   <= '0;
                        state <= COMPARE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                COMPARE: begin
                    wins      <= wins_nx;
                    round     <= round_nx;
                    rsp_cnt_a <= cnt_a;
                    rsp_cnt_b <= cnt_b;
                    if (round_nx < votes_q) begin
                        state <= SETTLE;
                    end else begin
                        // Majority test at VOTE_W+1 bits so 2*wins cannot wrap.
                        flags_q.bit_v <= {wins_nx, 1'b0} > {1'b0, votes_q};
                        flags_q.tie   <= {wins_nx, 1'b0} == {1'b0, votes_q};
                        rsp_wins      <= wins_nx;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign chal_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rsp_bit    = flags_q.bit_v;
    assign rsp_tie    = flags_q.tie;

endmodule

// File: tb/tb_puf_ro_pair_eval.sv
// Bench for puf_ro_pair_eval: synthetic RO lines with known toggle periods,
// expected responses queued at issue time and checked when the DUT answers.
module tb_puf_ro_pair_eval;

    localparam int N_RO   = 16;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 20;
    localparam int SAT_W  = 4;
    localparam int WIN_W  = 16;
    localparam int VOTE_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_RO-1:0]   ro_tgl = '0;

    logic              chal_valid = 1'b0, chal_ready;
    logic [SEL_W-1:0]  chal_sel_a = '0, chal_sel_b = '0;
    logic [WIN_W-1:0]  chal_win = '0;
    logic [VOTE_W-1:0] chal_votes = '0;
    logic              rsp_valid, rsp_ready = 1'b0, rsp_bit, rsp_tie, busy;
    logic [VOTE_W-1:0] rsp_wins;
    logic [CNT_W-1:0]  rsp_cnt_a, rsp_cnt_b;

    logic              s_chal_valid = 1'b0, s_chal_ready;
    logic [SEL_W-1:0]  s_sel_a = '0, s_sel_b = '0;
    logic [WIN_W-1:0]  s_win = '0;
    logic [VOTE_W-1:0] s_votes = '0;
    logic              s_rsp_valid, s_rsp_ready = 1'b0, s_rsp_bit, s_rsp_tie, s_busy;
    logic [VOTE_W-1:0] s_rsp_wins;
    logic [SAT_W-1:0]  s_cnt_a, s_cnt_b;

    typedef struct {
        int lat; int bit_v; int tie; int wins;
        int a_lo; int a_hi; int b_lo; int b_hi;
    } exp_t;

    exp_t sb[$];
    exp_t sb_sat[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   per[N_RO];
    int   ph[N_RO];
    int   cyc = 0;

    puf_ro_pair_eval #(.N_RO(N_RO), .CNT_W(CNT_W), .WIN_W(WIN_W), .VOTE_W(VOTE_W)) u_dut (
        .clk(clk), .rst(rst), .ro_tgl(ro_tgl),
        .chal_valid(chal_valid), .chal_ready(chal_ready),
        .chal_sel_a(chal_sel_a), .chal_sel_b(chal_sel_b),
        .chal_win(chal_win), .chal_votes(chal_votes),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_bit(rsp_bit), .rsp_tie(rsp_tie), .rsp_wins(rsp_wins),
        .rsp_cnt_a(rsp_cnt_a), .rsp_cnt_b(rsp_cnt_b), .busy(busy)
    );

    puf_ro_pair_eval #(.N_RO(N_RO), .CNT_W(SAT_W), .WIN_W(WIN_W), .VOTE_W(VOTE_W)) u_sat (
        .clk(clk), .rst(rst), .ro_tgl(ro_tgl),
        .chal_valid(s_chal_valid), .chal_ready(s_chal_ready),
        .chal_sel_a(s_sel_a), .chal_sel_b(s_sel_b),
        .chal_win(s_win), .chal_votes(s_votes),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_bit(s_rsp_bit), .rsp_tie(s_rsp_tie), .rsp_wins(s_rsp_wins),
        .rsp_cnt_a(s_cnt_a), .rsp_cnt_b(s_cnt_b), .busy(s_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < N_RO; i++)
            if (per[i] != 0 && ((cyc + ph[i]) % per[i]) == 0) ro_tgl[i] = ~ro_tgl[i];
    end

    function automatic exp_t mk(int lat, int b, int t, int w, int alo, int ahi, int blo, int bhi);
        exp_t e;
        e.lat = lat; e.bit_v = b; e.tie = t; e.wins = w;
        e.a_lo = alo; e.a_hi = ahi; e.b_lo = blo; e.b_hi = bhi;
        return e;
    endfunction

    task automatic send(input int sa, input int sbb, input int w, input int v);
        @(negedge clk);
        chal_sel_a = SEL_W'(sa);
        chal_sel_b = SEL_W'(sbb);
        chal_win   = WIN_W'(w);
        chal_votes = VOTE_W'(v);
        chal_valid = 1'b1;
        @(posedge clk);
        #1 chal_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({chal_ready, rsp_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_ctrl: ready/valid/busy=%b want 100", {chal_ready, rsp_valid, busy});
        end
        n_vec++;
        if ({rsp_bit, rsp_tie, rsp_wins, rsp_cnt_a, rsp_cnt_b} !== '0) begin
            n_err++;
            $display("FAIL reset_data: bit=%b tie=%b wins=%0d a=%0d b=%0d want all 0",
                     rsp_bit, rsp_tie, rsp_wins, rsp_cnt_a, rsp_cnt_b);
        end
        n_vec++;
        if ({s_chal_ready, s_rsp_valid, s_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_sat_ctrl: got %b want 100", {s_chal_ready, s_rsp_valid, s_busy});
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_a_faster();
        exp_t e;
        int   lat;
        sb.push_back(mk(405, 1, 0, 1, 99, 101, 49, 51));
        send(3, 5, 400, 1);
        wait_valid(600, lat);
        e = sb.pop_front();
        n_vec++;
        if (lat != e.lat) begin
            n_err++; $display("FAIL a_faster_latency: got %0d want %0d", lat, e.lat);
        end
        n_vec++;
        if (rsp_bit !== e.bit_v[0] || rsp_tie !== e.tie[0] || int'(rsp_wins) != e.wins) begin
            n_err++;
            $display("FAIL a_faster_flags: bit=%b tie=%b wins=%0d want %0d %0d %0d",
                     rsp_bit, rsp_tie, rsp_wins, e.bit_v, e.tie, e.wins);
        end
        n_vec++;
        if (int'(rsp_cnt_a) < e.a_lo || int'(rsp_cnt_a) > e.a_hi ||
            int'(rsp_cnt_b) < e.b_lo || int'(rsp_cnt_b) > e.b_hi) begin
            n_err++;
            $display("FAIL a_faster_counts: a=%0d b=%0d want a in [%0d,%0d] b in [%0d,%0d]",
                     rsp_cnt_a, rsp_cnt_b, e.a_lo, e.a_hi, e.b_lo, e.b_hi);
        end
        ack();
        n_vec++;
        if ({rsp_valid, chal_ready} !== 2'b01) begin
            n_err++; $display("FAIL a_faster_release: valid/ready=%b want 01", {rsp_valid, chal_ready});
        end
    endtask

    task automatic test_swap_busy();
        exp_t e;
        int   lat;
        int   bad = 0;
        sb.push_back(mk(5 * 405, 0, 0, 0, 49, 51, 99, 101));
        send(5, 3, 400, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chal_valid = 1'b1; chal_sel_a = 4'd7; chal_sel_b = 4'd0;
            chal_win = 16'd1; chal_votes = 4'd1;
            @(posedge clk);
            #1;
            if (chal_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        chal_valid = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL busy_ignore: ready high while busy in %0d cycles, want 0", bad);
        end
        wait_valid(2100, lat);
        e = sb.pop_front();
        n_vec++;
        if (lat + 10 != e.lat) begin
            n_err++; $display("FAIL swap_latency: got %0d want %0d", lat + 10, e.lat);
        end
        n_vec++;
        if (rsp_bit !== e.bit_v[0] || rsp_tie !== e.tie[0] || int'(rsp_wins) != e.wins) begin
            n_err++;
            $display("FAIL swap_flags: bit=%b tie=%b wins=%0d want %0d %0d %0d",
                     rsp_bit, rsp_tie, rsp_wins, e.bit_v, e.tie, e.wins);
        end
        n_vec++;
        if (int'(rsp_cnt_a) < e.a_lo || int'(rsp_cnt_a) > e.a_hi ||
            int'(rsp_cnt_b) < e.b_lo || int'(rsp_cnt_b) > e.b_hi) begin
            n_err++; $display("FAIL swap_counts: a=%0d b=%0d want ~50/~100", rsp_cnt_a, rsp_cnt_b);
        end
        ack();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL busy_no_queue: active in %0d cycles after ack, want 0", bad);
        end
    endtask

    task automatic test_same_sel();
        exp_t e;
        int   lat;
        sb.push_back(mk(4 * 105, 0, 0, 0, 16, 17, 16, 17));
        send(7, 7, 100, 4);
        wait_valid(600, lat);
        e = sb.pop_front();
        n_vec++;
        if (lat != e.lat) begin
            n_err++; $display("FAIL same_sel_latency: got %0d want %0d", lat, e.lat);
        end
        n_vec++;
        if (rsp_bit !== e.bit_v[0] || rsp_tie !== e.tie[0] || int'(rsp_wins) != e.wins) begin
            n_err++;
            $display("FAIL same_sel_flags: bit=%b tie=%b wins=%0d want 0 0 0", rsp_bit, rsp_tie, rsp_wins);
        end
        n_vec++;
        if (rsp_cnt_a !== rsp_cnt_b || int'(rsp_cnt_a) < e.a_lo || int'(rsp_cnt_a) > e.a_hi) begin
            n_err++;
            $display("FAIL same_sel_counts: a=%0d b=%0d want equal in [%0d,%0d]",
                     rsp_cnt_a, rsp_cnt_b, e.a_lo, e.a_hi);
        end
        ack();
    endtask

    // Window length 30 with a 35-cycle round walks the window start through all
    // four phases of the 4-cycle edge pattern, so each line wins twice.
    task automatic test_tie();
        exp_t e;
        int   lat;
        sb.push_back(mk(4 * 35, 0, 1, 2, 7, 8, 7, 8));
        send(9, 10, 30, 4);
        wait_valid(300, lat);
        e = sb.pop_front();
        n_vec++;
        if (lat != e.lat) begin
            n_err++; $display("FAIL tie_latency: got %0d want %0d", lat, e.lat);
        end
        n_vec++;
        if (rsp_bit !== e.bit_v[0] || rsp_tie !== e.tie[0] || int'(rsp_wins) != e.wins) begin
            n_err++;
            $display("FAIL tie_flags: bit=%b tie=%b wins=%0d want 0 1 2", rsp_bit, rsp_tie, rsp_wins);
        end
        n_vec++;
        if (int'(rsp_cnt_a) < e.a_lo || int'(rsp_cnt_a) > e.a_hi ||
            int'(rsp_cnt_b) < e.b_lo || int'(rsp_cnt_b) > e.b_hi) begin
            n_err++; $display("FAIL tie_counts: a=%0d b=%0d want 7..8", rsp_cnt_a, rsp_cnt_b);
        end
        ack();
    endtask

    task automatic test_saturate_hold();
        exp_t e;
        int   lat = -1;
        int   bad = 0;
        sb_sat.push_back(mk(205, 1, 0, 1, 15, 15, 0, 0));
        @(negedge clk);
        s_sel_a = 4'd3; s_sel_b = 4'd0; s_win = 16'd200; s_votes = 4'd1;
        s_chal_valid = 1'b1;
        @(posedge clk);
        #1 s_chal_valid = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (s_rsp_valid) begin
                lat = i;
                break;
            end
        end
        e = sb_sat.pop_front();
        n_vec++;
        if (lat != e.lat) begin
            n_err++; $display("FAIL sat_latency: got %0d want %0d", lat, e.lat);
        end
        for (int i = 0; i < 20; i++) begin
            if (s_rsp_valid !== 1'b1 || s_chal_ready !== 1'b0 || s_busy !== 1'b1 ||
                s_rsp_bit !== e.bit_v[0] || s_rsp_tie !== e.tie[0] || int'(s_rsp_wins) != e.wins ||
                int'(s_cnt_a) != e.a_lo || int'(s_cnt_b) != e.b_lo) bad++;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL sat_hold: %0d unstable cycles, a=%0d b=%0d bit=%b want a=15 b=0 bit=1",
                     bad, s_cnt_a, s_cnt_b, s_rsp_bit);
        end
        s_rsp_ready = 1'b1;
        @(posedge clk);
        #1 s_rsp_ready = 1'b0;
        n_vec++;
        if ({s_rsp_valid, s_chal_ready} !== 2'b01) begin
            n_err++; $display("FAIL sat_release: valid/ready=%b want 01", {s_rsp_valid, s_chal_ready});
        end
    endtask

    task automatic test_rst_mid();
        exp_t e;
        int   lat;
        int   bad = 0;
        send(3, 5, 400, 1);
        repeat (100) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({rsp_valid, busy, chal_ready} !== 3'b001 || rsp_cnt_a !== '0 || rsp_wins !== '0) begin
            n_err++;
            $display("FAIL rst_mid_state: valid/busy/ready=%b a=%0d wins=%0d want 001 0 0",
                     {rsp_valid, busy, chal_ready}, rsp_cnt_a, rsp_wins);
        end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 450; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL rst_mid_stale: active in %0d cycles, want 0", bad);
        end
        sb.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0));
        send(0, 0, 0, 0);
        wait_valid(50, lat);
        e = sb.pop_front();
        n_vec++;
        if (lat != e.lat) begin
            n_err++; $display("FAIL zero_fields_latency: got %0d want %0d", lat, e.lat);
        end
        n_vec++;
        if (rsp_bit !== e.bit_v[0] || rsp_tie !== e.tie[0] || int'(rsp_wins) != e.wins ||
            int'(rsp_cnt_a) != e.a_lo || int'(rsp_cnt_b) != e.b_lo) begin
            n_err++;
            $display("FAIL zero_fields_rsp: bit=%b tie=%b wins=%0d a=%0d b=%0d want all 0",
                     rsp_bit, rsp_tie, rsp_wins, rsp_cnt_a, rsp_cnt_b);
        end
        ack();
    endtask

    initial begin
        for (int i = 0; i < N_RO; i++) begin
            per[i] = 0;
            ph[i]  = 0;
        end
        per[3]  = 4;
        per[5]  = 8;
        per[7]  = 6;
        per[9]  = 4;
        per[10] = 4;
        ph[10]  = 2;
        test_reset();
        repeat (10) @(posedge clk);
        test_a_faster();
        test_swap_busy();
        test_same_sel();
        test_tie();
        test_saturate_hold();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/puf_ro_pair_eval.md
Name: puf_ro_pair_eval

Overview:
- Parametrised ring-oscillator PUF evaluation engine for the PUF experiment platforms; the successor to the fixed PS-only top.
- Sits in PL fabric behind a register bridge.
- Takes N_RO divided-down RO toggle lines, and per challenge counts edges of two selected oscillators over a programmable gate window.
- Repeats for a programmable number of rounds and returns a majority-voted response bit plus the raw counts of the last round over a valid/ready handshake.

Parameters:
- N_RO, 16, number of RO toggle inputs (2..256)
- SEL_W, $clog2(N_RO), width of the oscillator select fields
- CNT_W, 20, edge-counter width
- WIN_W, 16, gate-window length field width (clk cycles)
- VOTE_W, 4, round-count field width
- SYNC_STAGES, 2, synchroniser depth per RO line (2..4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ro_tgl  in  N_RO  asynchronous RO toggle lines; each line's frequency is ≤ clk/4
- chal_valid  in  1  challenge valid
- chal_ready  out  1  high only in IDLE
- chal_sel_a  in  SEL_W  oscillator A index
- chal_sel_b  in  SEL_W  oscillator B index
- chal_win  in  WIN_W  gate length in cycles; 0 is treated as 1
- chal_votes  in  VOTE_W  round count; 0 is treated as 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_bit  out  1  majority result, 1 = A faster
- rsp_tie  out  1  even split of round wins
- rsp_wins  out  VOTE_W  rounds won by A
- rsp_cnt_a  out  CNT_W  last-round edge count of A
- rsp_cnt_b  out  CNT_W  last-round edge count of B
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; chal_ready=1; rsp_valid=0; rsp_bit, rsp_tie, rsp_wins, rsp_cnt_a, rsp_cnt_b, busy all 0; synchronisers cleared.
- Synchronisers: every RO line passes through SYNC_STAGES flops plus one history flop, free-running in all states. An edge is a change between the last sync stage and the history flop; both polarities count.
- Challenge capture: on chal_valid&&chal_ready, latch sel_a, sel_b, win (0→1) and votes (0→1). Out-of-range index (≥N_RO) is latched modulo-free and selects ro_tgl[0].
- FSM: IDLE → SETTLE → COUNT → COMPARE, then → SETTLE again or → RESP.
- SETTLE: exactly 4 cycles; clears cnt_a and cnt_b; the edge detectors see the selected mux outputs.
- COUNT: exactly win cycles. Each counter increments by 1 per detected edge of its selected line and saturates at 2^CNT_W-1.
- COMPARE: 1 cycle. If cnt_a > cnt_b, wins += 1. An equal count is a round loss for A. round += 1. Counts are copied to rsp_cnt_a/b. Next state is SETTLE if round < votes, else RESP.
- RESP: on entry, rsp_bit = (2*wins > votes), rsp_tie = (2*wins == votes), rsp_wins = wins; rsp_valid=1. Outputs are held stable until rsp_ready; rsp_valid&&rsp_ready → IDLE (rsp_valid low next cycle). chal_ready rises in the same cycle.
- Latency: one round = win+5 cycles. With acceptance at edge T, rsp_valid is first high in cycle T + votes*(win+5) + 1.
- sel_a == sel_b: evaluated normally; counts are equal, so wins=0 and rsp_bit=0 (rsp_tie=0 for odd votes).
- chal_valid while busy: ignored; no queueing.
- rst mid-operation: immediate return to IDLE; partial results discarded; no response is produced.
- Width rules: wins and round are VOTE_W bits and cannot overflow because votes ≤ 2^VOTE_W-1. The 2*wins comparison is done at VOTE_W+1 bits.

Decomposition:
- Package puf_pkg: FSM state enum (IDLE, SETTLE, COUNT, COMPARE, RESP), SETTLE_CYCLES=4 constant, response struct typedef.
- Sub-module puf_ro_edge_sync: one per RO line, generate loop. Contains SYNC_STAGES flops, history flop and edge pulse output.
- Top level contains the two selection muxes, the two saturating counters, the round/vote logic and the FSM.

Test Plan:
- A toggles every 4 clk, B every 8 clk; sel_a=3, sel_b=5, win=400, votes=1 → rsp_cnt_a≈100±1, rsp_cnt_b≈50±1, rsp_bit=1, rsp_wins=1, rsp_valid first in cycle T+406.
- Swap selections, votes=5 → rsp_bit=0, rsp_wins=0, rsp_tie=0; rsp_valid at T+5*405+1.
- sel_a=sel_b=7, votes=4 → counts equal, rsp_wins=0, rsp_bit=0, rsp_tie=0.
- Equal-frequency lines whose phase gives alternating round wins, votes=4 → rsp_wins=2, rsp_tie=1, rsp_bit=0.
- CNT_W=4, A toggling every 4 clk, win=200 → rsp_cnt_a=15 (saturated); hold rsp_ready low 20 cycles → outputs stable and chal_ready=0 throughout.
- rst asserted mid-COUNT, then new challenge with win=0, votes=0 → no stale response; operates as win=1, votes=1, rsp_valid at T+7.
